// File: rtl/pad_cfg_pkg.sv
// pad_cfg_pkg: shared widths, control-word bit positions and address decode for the pad config loader.
package pad_cfg_pkg;

    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 10;
    localparam int NUM_REGS    = 16;
    localparam int COMMIT_ADDR = 31;
    localparam int REG_IDX_W   = $clog2(NUM_REGS);

    localparam int CMD_COMMIT_BIT = 0;
    localparam int CMD_CLEAR_BIT  = 1;
    localparam int CMD_ERRCLR_BIT = 2;

    typedef enum logic [REG_IDX_W-1:0] {
        REG_TRNG_CTRL = 4'd0,
        REG_TRNG_THR  = 4'd1,
        REG_TRNG_NOISE = 4'd2,
        REG_PLL_DIV   = 4'd3,
        REG_PLL_CTRL  = 4'd4,
        REG_PLL_TRIM  = 4'd5,
        REG_VB_BIAS0  = 4'd6,
        REG_VB_BIAS1  = 4'd7
    } cfg_reg_e;

    typedef enum logic [1:0] {
        AK_REG,
        AK_CMD,
        AK_BAD
    } addr_kind_e;

    function automatic addr_kind_e decode_addr(input logic [ADDR_W-1:0] a);
        return (a < ADDR_W'(NUM_REGS)) ? AK_REG :
               (a == ADDR_W'(COMMIT_ADDR)) ? AK_CMD : AK_BAD;
    endfunction

endpackage

// File: rtl/pad_cfg_loader_sync.sv
// pad_in_sync: multi-flop synchronizer for slow asynchronous pad inputs.
module pad_in_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] sync_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pad_cfg_loader.sv
// pad_cfg_loader: synchronizes and glitch-filters pad write strobes into a staging bank,
// committed atomically to the active configuration bus.
module pad_cfg_loader
    import pad_cfg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid,
    input  logic [ADDR_W-1:0]          addr,
    input  logic [DATA_W-1:0]          data,
    output logic [NUM_REGS*DATA_W-1:0] cfg_o,
    output logic                       cfg_update_o,
    output logic [7:0]                 wr_cnt_o,
    output logic                       err_o
);

    localparam int HW = $clog2(MIN_HIGH + 1);

    logic              valid_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;
    logic [HW-1:0]     hi_cnt_q, hi_cnt_d;
    logic [DATA_W-1:0] staging_q [NUM_REGS];
    logic [DATA_W-1:0] staging_d [NUM_REGS];
    logic [DATA_W-1:0] active_q [NUM_REGS];
    logic [DATA_W-1:0] active_d [NUM_REGS];
    logic              commit_pend_q, commit_pend_d;
    logic              clr_pend_q, clr_pend_d;
    logic              cfg_update_q, cfg_update_d;
    logic              err_q, err_d;
    logic [7:0]        wr_cnt_q, wr_cnt_d;
    logic              acc;
    addr_kind_e        kind;

    pad_in_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_valid (
        .clk(clk), .rst_n(rst_n), .d_i(valid), .q_o(valid_s)
    );
    pad_in_sync #(.W(ADDR_W), .STAGES(SYNC_STAGES)) u_sync_addr (
        .clk(clk), .rst_n(rst_n), .d_i(addr), .q_o(addr_s)
    );
    pad_in_sync #(.W(DATA_W), .STAGES(SYNC_STAGES)) u_sync_data (
        .clk(clk), .rst_n(rst_n), .d_i(data), .q_o(data_s)
    );

    // A combined commit+clear defers the clear to the commit edge so the copy sees pre-clear staging.
    always_comb begin
        acc           = valid_s && (hi_cnt_q == HW'(MIN_HIGH - 1));
        kind          = decode_addr(addr_s);
        hi_cnt_d      = !valid_s ? '0 : (hi_cnt_q == HW'(MIN_HIGH)) ? hi_cnt_q : hi_cnt_q + 1'b1;
        staging_d     = staging_q;
        active_d      = active_q;
        commit_pend_d = 1'b0;
        clr_pend_d    = 1'b0;
        cfg_update_d  = commit_pend_q;
        err_d         = err_q;
        wr_cnt_d      = wr_cnt_q;
        if (commit_pend_q) begin
            active_d = staging_q;
            if (clr_pend_q) for (int k = 0; k < NUM_REGS; k++) staging_d[k] = '0;
        end
        if (acc) begin
            if (kind != AK_BAD && wr_cnt_q != 8'hFF) wr_cnt_d = wr_cnt_q + 1'b1;
            if (kind == AK_REG) staging_d[addr_s[REG_IDX_W-1:0]] = data_s;
            if (kind == AK_CMD) begin
                commit_pend_d = data_s[CMD_COMMIT_BIT];
                clr_pend_d    = data_s[CMD_COMMIT_BIT] & data_s[CMD_CLEAR_BIT];
                if (data_s[CMD_CLEAR_BIT] && !data_s[CMD_COMMIT_BIT])
                    for (int k = 0; k < NUM_REGS; k++) staging_d[k] = '0;
                if (data_s[CMD_ERRCLR_BIT]) err_d = 1'b0;
            end
            if (kind == AK_BAD) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt_q      <= '0;
            commit_pend_q <= 1'b0;
            clr_pend_q    <= 1'b0;
            cfg_update_q  <= 1'b0;
            err_q         <= 1'b0;
            wr_cnt_q      <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                staging_q[k] <= '0;
                active_q[k]  <= '0;
            end
        end else begin
            hi_cnt_q      <= hi_cnt_d;
            commit_pend_q <= commit_pend_d;
            clr_pend_q    <= clr_pend_d;
            cfg_update_q  <= cfg_update_d;
            err_q         <= err_d;
            wr_cnt_q      <= wr_cnt_d;
            staging_q     <= staging_d;
            active_q      <= active_d;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cfg
        assign cfg_o[i*DATA_W +: DATA_W] = active_q[i];
    end

    assign cfg_update_o = cfg_update_q;
    assign wr_cnt_o     = wr_cnt_q;
    assign err_o        = err_q;

endmodule
